// File: rtl/cpu_phase_controller.sv
// ============================================================================
// cpu_phase_controller : multicycle IF/ID/EX/MEM/WB sequencer with ready
//                        handshakes, wait timeout, halt and retire counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module cpu_phase_controller #(
   parameter int COUNT_SIZE = 32,
   parameter int WAIT_SIZE  = 4,
   parameter int MAX_WAIT   = 15
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  halt_request,
   input  logic                  im_ready,
   input  logic                  dm_ready,
   input  logic                  is_mem_op,
   output logic                  do_im_read,
   output logic                  do_reg_fetch,
   output logic                  do_execute,
   output logic                  do_dm_access,
   output logic                  do_reg_write,
   output logic                  pc_update,
   output logic                  busy,
   output logic                  fault,
   output logic [COUNT_SIZE-1:0] retired_count
);

   // Last wait value still allowed; one more idle cycle past it is a timeout.
   localparam logic [WAIT_SIZE-1:0] WAIT_LAST = WAIT_SIZE'(MAX_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_IF     = 3'd1,
      S_ID     = 3'd2,
      S_EX     = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALTED = 3'd6,
      S_FAULT  = 3'd7
   } state_t;

   state_t                 state;
   state_t                 next_state;
   logic [WAIT_SIZE-1:0]   wait_cnt;
   logic                   waiting;

   always_comb begin
      next_state = state;
      waiting    = 1'b0;
      case (state)
         S_IDLE: if (start) next_state = S_IF;
         S_IF: begin
            if (im_ready)                next_state = S_ID;
            else if (wait_cnt == WAIT_LAST) next_state = S_FAULT;
            else                         waiting    = 1'b1;
         end
         S_ID:  next_state = S_EX;
         S_EX:  next_state = is_mem_op ? S_MEM : S_WB;
         S_MEM: begin
            if (dm_ready)                next_state = S_WB;
            else if (wait_cnt == WAIT_LAST) next_state = S_FAULT;
            else                         waiting    = 1'b1;
         end
         S_WB:    next_state = halt_request ? S_HALTED : S_IF;
         default: next_state = state;
      endcase
   end

   // Strobes are decoded from next_state so they line up with the state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         wait_cnt      <= '0;
         retired_count <= '0;
         do_im_read    <= 1'b0;
         do_reg_fetch  <= 1'b0;
         do_execute    <= 1'b0;
         do_dm_access  <= 1'b0;
         do_reg_write  <= 1'b0;
         pc_update     <= 1'b0;
         busy          <= 1'b0;
         fault         <= 1'b0;
      end else begin
         state <= next_state;
         if (next_state != state)
            wait_cnt <= '0;
         else if (waiting)
            wait_cnt <= wait_cnt + WAIT_SIZE'(1);
         if (state == S_WB)
            retired_count <= retired_count + COUNT_SIZE'(1);
         do_im_read   <= (next_state == S_IF);
         do_reg_fetch <= (next_state == S_ID);
         do_execute   <= (next_state == S_EX);
         do_dm_access <= (next_state == S_MEM);
         do_reg_write <= (next_state == S_WB);
         pc_update    <= (next_state == S_WB);
         busy         <= (next_state == S_IF) || (next_state == S_ID) ||
                         (next_state == S_EX) || (next_state == S_MEM) ||
                         (next_state == S_WB);
         fault        <= (next_state == S_FAULT);
      end
   end

endmodule

`default_nettype wire

// File: doc/cpu_phase_controller.md
Name: cpu_phase_controller

Overview:
Multicycle sequencer that initiates every register-file and memory access in the core. It drives do_reg_fetch and do_reg_write toward the register file, and im/dm request strobes toward the memories. Each instruction is stepped through IF, ID, EX, optional MEM and WB phases, with ready handshakes, a wait timeout, halt handling and a retired-instruction counter.

Parameters:
CountSize, 32, width of retired-instruction counter
WaitSize, 4, width of wait-cycle counter
MaxWait, 15, max cycles a request may wait for ready before fault (must fit in WaitSize)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  level; leaves IDLE when high
halt_request  input  1  sampled in WB; stop after current instruction
im_ready  input  1  instruction memory data valid
dm_ready  input  1  data memory access complete
is_mem_op  input  1  decoder flag, sampled in EX: instruction needs MEM phase
do_im_read  output  1  instruction fetch request (IF state)
do_reg_fetch  output  1  register file read strobe (ID state)
do_execute  output  1  ALU operand/result latch enable (EX state)
do_dm_access  output  1  data memory request (MEM state)
do_reg_write  output  1  register file write strobe (WB state); regfile gates it with its own enable_reg_write
pc_update  output  1  one-cycle pulse in WB: PC advances
busy  output  1  high in every state except IDLE, HALTED, FAULT
fault  output  1  sticky wait-timeout flag
retired_count  output  CountSize  instructions completed since reset

Behaviour:
- States: IDLE, IF, ID, EX, MEM, WB, HALTED, FAULT. State register is async-reset to IDLE.
- All do_*, pc_update and busy are decoded from the state register only (Moore). No input reaches an output combinationally.
- Reset values: state=IDLE, all strobes 0, busy=0, fault=0, retired_count=0, wait counter=0.
- IDLE: stay while start=0. Go to IF when start=1.
- IF: do_im_read=1. Go to ID on the cycle im_ready=1. Otherwise increment the wait counter.
- ID: do_reg_fetch=1 for exactly one cycle, then EX.
- EX: do_execute=1 for one cycle. If is_mem_op=1, go to MEM. Otherwise go to WB.
- MEM: do_dm_access=1. Go to WB on the cycle dm_ready=1. Otherwise increment the wait counter.
- WB: do_reg_write=1 and pc_update=1 for one cycle. retired_count increments (wraps modulo 2^CountSize). Next state is HALTED if halt_request=1, otherwise IF.
- HALTED: all strobes 0. Leave only through reset.
- Wait counter clears on every state entry. If it reaches MaxWait while still waiting in IF or MEM, the next state is FAULT. A ready arriving on that same cycle wins: the normal transition is taken and there is no fault.
- FAULT: fault=1, all strobes 0. Sticky until reset. retired_count does not increment.
- Latency: a non-memory instruction with im_ready already high takes 4 cycles (IF, ID, EX, WB). A memory instruction with both readies immediate takes 5. Each wait cycle adds 1.
- Readies are ignored outside their own state; im_ready high in ID has no effect.
- halt_request is ignored outside WB. A halt pending on the WB cycle completes that instruction's writeback.
- start is ignored outside IDLE.
- Reset asserted mid-instruction immediately returns to IDLE and drops all strobes. No partial do_reg_write is produced.
- do_reg_fetch and do_reg_write are never high in the same cycle.

Test Plan:
- Reset, then start=1 with im_ready=1 and is_mem_op=0 -> IF, ID, EX, WB each exactly 1 cycle; do_reg_write at cycle 4; retired_count=1 after WB; 3 instructions -> retired_count=3 at cycle 12.
- is_mem_op=1, dm_ready held low 3 cycles then high -> do_dm_access high 4 cycles, then WB; instruction takes 8 cycles total.
- im_ready held low for MaxWait=15 cycles -> FAULT entered; fault=1 sticky, busy=0, no further strobes; im_ready rising on the 15th cycle instead -> ID, fault=0.
- halt_request=1 asserted during EX and held -> WB completes (do_reg_write=1 once) -> HALTED, busy=0; start toggling has no effect.
- Reset pulsed while in MEM -> all outputs 0 asynchronously, state IDLE, retired_count=0; then start=1 -> normal IF.
- Preload retired_count to its maximum value (force or CountSize=4 with 16 instructions) -> wraps to 0 on the next WB.
